// File: rtl/switch_mcu_alu_exec.sv
// Multi-cycle RV32I integer execution unit for the switch MCU core.
// Reads operands from the regfile, computes ALU or iterative shift results, and writes back.
module switch_mcu_alu_exec #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int SHIFT_STEP = 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    input  logic [3:0]        in_op,
    input  logic              in_use_imm,
    input  logic [11:0]       in_imm,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    output logic [REG_AW-1:0] out_raddr_1,
    output logic              out_ren_1,
    input  logic [XLEN-1:0]   in_rdata_1,
    output logic [REG_AW-1:0] out_raddr_2,
    output logic              out_ren_2,
    input  logic [XLEN-1:0]   in_rdata_2,
    output logic [REG_AW-1:0] out_waddr,
    output logic              out_wen,
    output logic [XLEN-1:0]   out_wdata,
    output logic              out_busy,
    output logic              out_done
);

    localparam int SAW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_SHIFT,
        S_WB
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              use_imm_q, use_imm_d;
    logic [11:0]       imm_q, imm_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [SAW-1:0]    cnt_q, cnt_d;

    logic [REG_AW-1:0] raddr_1_q, raddr_1_d;
    logic              ren_1_q, ren_1_d;
    logic [REG_AW-1:0] raddr_2_q, raddr_2_d;
    logic              ren_2_q, ren_2_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [XLEN-1:0]   b_val;
    logic [XLEN-1:0]   alu_res;
    logic              alu_legal;
    logic              is_shift;
    logic [XLEN-1:0]   shift_res;
    logic [SAW-1:0]    cnt_next;
    logic              fin;
    logic              fin_legal;
    logic [XLEN-1:0]   fin_data;

    always_comb begin
        b_val     = use_imm_q ? {{(XLEN-12){imm_q[11]}}, imm_q} : in_rdata_2;
        alu_legal = 1'b1;
        alu_res   = '0;
        case (op_q)
            OP_ADD:  alu_res = in_rdata_1 + b_val;
            OP_SUB:  alu_res = in_rdata_1 - b_val;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_rdata_1) < $signed(b_val)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_rdata_1 < b_val};
            OP_XOR:  alu_res = in_rdata_1 ^ b_val;
            OP_OR:   alu_res = in_rdata_1 | b_val;
            OP_AND:  alu_res = in_rdata_1 & b_val;
            OP_SLL, OP_SRL, OP_SRA: alu_res = '0;
            default: alu_legal = 1'b0;
        endcase
        is_shift = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);

        // Chain of single-bit stages: only the first min(cnt, SHIFT_STEP) are applied.
        shift_res = acc_q;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (i < int'(cnt_q)) begin
                case (op_q)
                    OP_SLL:  shift_res = {shift_res[XLEN-2:0], 1'b0};
                    OP_SRA:  shift_res = {shift_res[XLEN-1], shift_res[XLEN-1:1]};
                    default: shift_res = {1'b0, shift_res[XLEN-1:1]};
                endcase
            end
        end
        cnt_next = (int'(cnt_q) > SHIFT_STEP) ? cnt_q - SAW'(SHIFT_STEP) : '0;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        raddr_1_d = '0;
        ren_1_d   = 1'b0;
        raddr_2_d = '0;
        ren_2_d   = 1'b0;
        waddr_d   = '0;
        wen_d     = 1'b0;
        wdata_d   = '0;
        done_d    = 1'b0;
        fin       = 1'b0;
        fin_legal = 1'b1;
        fin_data  = '0;

        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    op_d      = in_op;
                    use_imm_d = in_use_imm;
                    imm_d     = in_imm;
                    rd_d      = in_rd;
                    ren_1_d   = 1'b1;
                    raddr_1_d = in_rs1;
                    if (!in_use_imm) begin
                        ren_2_d   = 1'b1;
                        raddr_2_d = in_rs2;
                    end
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_EX;
            S_EX: begin
                if (is_shift) begin
                    acc_d = in_rdata_1;
                    cnt_d = b_val[SAW-1:0];
                    if (b_val[SAW-1:0] == '0) begin
                        fin      = 1'b1;
                        fin_data = in_rdata_1;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    fin       = 1'b1;
                    fin_legal = alu_legal;
                    fin_data  = alu_res;
                end
            end
            S_SHIFT: begin
                acc_d = shift_res;
                cnt_d = cnt_next;
                if (cnt_next == '0) begin
                    fin      = 1'b1;
                    fin_data = shift_res;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Write-back outputs are registered on entry to WB so they line up with the WB cycle.
        if (fin) begin
            state_d = S_WB;
            done_d  = 1'b1;
            waddr_d = rd_q;
            if (fin_legal && (rd_q != '0)) begin
                wen_d   = 1'b1;
                wdata_d = fin_data;
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            rd_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            raddr_1_q <= '0;
            ren_1_q   <= 1'b0;
            raddr_2_q <= '0;
            ren_2_q   <= 1'b0;
            waddr_q   <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            raddr_1_q <= raddr_1_d;
            ren_1_q   <= ren_1_d;
            raddr_2_q <= raddr_2_d;
            ren_2_q   <= ren_2_d;
            waddr_q   <= waddr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out_raddr_1 = raddr_1_q;
    assign out_ren_1   = ren_1_q;
    assign out_raddr_2 = raddr_2_q;
    assign out_ren_2   = ren_2_q;
    assign out_waddr   = waddr_q;
    assign out_wen     = wen_q;
    assign out_wdata   = wdata_q;
    assign out_busy    = busy_q;
    assign out_done    = done_q;

endmodule

// File: tb/tb_switch_mcu_alu_exec.sv
// Directed-vector bench for switch_mcu_alu_exec, run against a SHIFT_STEP=1 and a SHIFT_STEP=4 instance.
// A behavioural regfile answers reads one cycle after ren; expected results are hand-computed.
module tb_switch_mcu_alu_exec;

    logic        in_clk;
    logic        in_rst;
    logic        in_start;
    logic [3:0]  in_op;
    logic        in_use_imm;
    logic [11:0] in_imm;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;

    logic [4:0]  raddr_1 [2];
    logic        ren_1   [2];
    logic [31:0] rdata_1 [2];
    logic [4:0]  raddr_2 [2];
    logic        ren_2   [2];
    logic [31:0] rdata_2 [2];
    logic [4:0]  waddr   [2];
    logic        wen     [2];
    logic [31:0] wdata   [2];
    logic        busy    [2];
    logic        done    [2];

    logic [31:0] regs [32];

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        use_imm;
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        exp_wen;
        logic        chk_data;
        logic [31:0] exp_data;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t vecs [$];

    switch_mcu_alu_exec #(.XLEN(32), .REG_AW(5), .SHIFT_STEP(1)) dut_s1 (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_op(in_op),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_raddr_1(raddr_1[0]), .out_ren_1(ren_1[0]), .in_rdata_1(rdata_1[0]),
        .out_raddr_2(raddr_2[0]), .out_ren_2(ren_2[0]), .in_rdata_2(rdata_2[0]),
        .out_waddr(waddr[0]), .out_wen(wen[0]), .out_wdata(wdata[0]),
        .out_busy(busy[0]), .out_done(done[0])
    );

    switch_mcu_alu_exec #(.XLEN(32), .REG_AW(5), .SHIFT_STEP(4)) dut_s4 (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_op(in_op),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_raddr_1(raddr_1[1]), .out_ren_1(ren_1[1]), .in_rdata_1(rdata_1[1]),
        .out_raddr_2(raddr_2[1]), .out_ren_2(ren_2[1]), .in_rdata_2(rdata_2[1]),
        .out_waddr(waddr[1]), .out_wen(wen[1]), .out_wdata(wdata[1]),
        .out_busy(busy[1]), .out_done(done[1])
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Read data is only meaningful the cycle after ren; poison it otherwise.
    for (genvar g = 0; g < 2; g++) begin : g_regfile
        always @(posedge in_clk) begin
            rdata_1[g] <= ren_1[g] ? regs[raddr_1[g]] : 32'hDEADBEEF;
            rdata_2[g] <= ren_2[g] ? regs[raddr_2[g]] : 32'hDEADBEEF;
        end
    end

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic use_imm,
                                input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic exp_wen, input logic chk_data,
                                input logic [31:0] exp_data, input int lat1, input int lat4);
        vec_t v;
        v.name = name; v.op = op; v.use_imm = use_imm; v.imm = imm;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.exp_wen = exp_wen; v.chk_data = chk_data;
        v.exp_data = exp_data; v.lat1 = lat1; v.lat4 = lat4;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one op; optionally re-pulses start while busy, or pulls reset at cycle rst_at.
    task automatic applyStimulus(input vec_t v, input int extra_start, input int rst_at);
        int          done_cnt  [2];
        int          wen_cnt   [2];
        int          done_cyc  [2];
        logic [4:0]  waddr_at  [2];
        logic [31:0] wdata_at  [2];
        logic        ren2_seen [2];
        logic        busy_at1  [2];
        logic        ren1_at1  [2];
        logic [4:0]  raddr1_at [2];
        int          exp_dones;
        exp_dones = (rst_at == 0) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0; wen_cnt[i] = 0; done_cyc[i] = 0; waddr_at[i] = '0; wdata_at[i] = '0;
            ren2_seen[i] = 1'b0; busy_at1[i] = 1'b0; ren1_at1[i] = 1'b0; raddr1_at[i] = '0;
        end

        @(negedge in_clk);
        in_op = v.op; in_use_imm = v.use_imm; in_imm = v.imm;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        in_op = 4'd1; in_use_imm = ~v.use_imm; in_imm = 12'h5A5; in_rs1 = 5'd30; in_rs2 = 5'd29; in_rd = 5'd31;

        for (int n = 1; n <= 45; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    if (done_cnt[i] == 0) begin
                        done_cyc[i] = n; waddr_at[i] = waddr[i]; wdata_at[i] = wdata[i];
                    end
                    done_cnt[i]++;
                end
                if (wen[i]) wen_cnt[i]++;
                if (ren_2[i]) ren2_seen[i] = 1'b1;
                if (n == 1) begin
                    busy_at1[i] = busy[i]; ren1_at1[i] = ren_1[i]; raddr1_at[i] = raddr_1[i];
                end
            end
            if (n == extra_start) begin
                in_start = 1'b1; in_op = 4'd0; in_use_imm = 1'b0; in_rs1 = 5'd1; in_rs2 = 5'd3; in_rd = 5'd9;
            end else begin
                in_start = 1'b0;
            end
            if (n == rst_at) begin
                in_rst = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    checkOutput($sformatf("%s/dut%0d/rst_ctrl", v.name, i),
                                {12'd0, busy[i], done[i], wen[i], ren_1[i], ren_2[i],
                                 raddr_1[i], raddr_2[i], waddr[i]}, 32'd0);
                    checkOutput($sformatf("%s/dut%0d/rst_wdata", v.name, i), wdata[i], 32'd0);
                end
            end
            if (n == rst_at + 2) in_rst = 1'b1;
            @(negedge in_clk);
        end

        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s/dut%0d/busy_c1", v.name, i), {31'd0, busy_at1[i]}, 32'd1);
            checkOutput($sformatf("%s/dut%0d/ren1_c1", v.name, i), {31'd0, ren1_at1[i]}, 32'd1);
            checkOutput($sformatf("%s/dut%0d/raddr1", v.name, i), {27'd0, raddr1_at[i]}, {27'd0, v.rs1});
            checkOutput($sformatf("%s/dut%0d/ren2_used", v.name, i), {31'd0, ren2_seen[i]}, {31'd0, ~v.use_imm});
            checkOutput($sformatf("%s/dut%0d/done_count", v.name, i), done_cnt[i], exp_dones);
            checkOutput($sformatf("%s/dut%0d/wen_count", v.name, i), wen_cnt[i], {31'd0, v.exp_wen});
            checkOutput($sformatf("%s/dut%0d/busy_end", v.name, i), {31'd0, busy[i]}, 32'd0);
            if (exp_dones == 1) begin
                checkOutput($sformatf("%s/dut%0d/latency", v.name, i), done_cyc[i], (i == 0) ? v.lat1 : v.lat4);
            end
            if (v.chk_data) begin
                checkOutput($sformatf("%s/dut%0d/waddr", v.name, i), {27'd0, waddr_at[i]},
                            v.exp_wen ? {27'd0, v.rd} : 32'd0);
                checkOutput($sformatf("%s/dut%0d/wdata", v.name, i), wdata_at[i], v.exp_data);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        regs[1] = 32'h0000_0010; regs[2] = 32'h0000_0000; regs[3] = 32'h0000_0001;
        regs[4] = 32'hFFFF_FFFF; regs[6] = 32'h8000_0000; regs[7] = 32'd31;
        regs[8] = 32'hF0F0_F0F0; regs[9] = 32'h0F0F_0F0F;

        //          name          op    imm? imm      rs1   rs2   rd    wen   chk   data           l1  l4
        vecs.push_back(mk("addi",     4'd0, 1, 12'hFFF, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'h0000_000F,  3,  3));
        vecs.push_back(mk("sub",      4'd1, 0, 12'h000, 5'd2, 5'd3, 5'd6, 1'b1, 1'b1, 32'hFFFF_FFFF,  3,  3));
        vecs.push_back(mk("add_wrap", 4'd0, 0, 12'h000, 5'd4, 5'd3, 5'd7, 1'b1, 1'b1, 32'h0000_0000,  3,  3));
        vecs.push_back(mk("slt",      4'd3, 0, 12'h000, 5'd4, 5'd3, 5'd8, 1'b1, 1'b1, 32'h0000_0001,  3,  3));
        vecs.push_back(mk("sltu",     4'd4, 0, 12'h000, 5'd4, 5'd3, 5'd8, 1'b1, 1'b1, 32'h0000_0000,  3,  3));
        vecs.push_back(mk("slti_min", 4'd3, 1, 12'h800, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 32'h0000_0000,  3,  3));
        vecs.push_back(mk("or",       4'd8, 0, 12'h000, 5'd8, 5'd3, 5'd10, 1'b1, 1'b1, 32'hF0F0_F0F1, 3,  3));
        vecs.push_back(mk("and",      4'd9, 0, 12'h000, 5'd4, 5'd8, 5'd11, 1'b1, 1'b1, 32'hF0F0_F0F0, 3,  3));
        vecs.push_back(mk("sra31",    4'd7, 0, 12'h000, 5'd6, 5'd7, 5'd12, 1'b1, 1'b1, 32'hFFFF_FFFF, 34, 11));
        vecs.push_back(mk("srl31",    4'd6, 0, 12'h000, 5'd6, 5'd7, 5'd13, 1'b1, 1'b1, 32'h0000_0001, 34, 11));
        vecs.push_back(mk("srai0",    4'd7, 1, 12'h400, 5'd6, 5'd0, 5'd14, 1'b1, 1'b1, 32'h8000_0000, 3,  3));
        vecs.push_back(mk("srai31",   4'd7, 1, 12'h41F, 5'd6, 5'd0, 5'd14, 1'b1, 1'b1, 32'hFFFF_FFFF, 34, 11));
        vecs.push_back(mk("slli4",    4'd2, 1, 12'h404, 5'd1, 5'd0, 5'd15, 1'b1, 1'b1, 32'h0000_0100, 7,  4));
        vecs.push_back(mk("srli5",    4'd6, 1, 12'h005, 5'd4, 5'd0, 5'd16, 1'b1, 1'b1, 32'h07FF_FFFF, 8,  5));
        vecs.push_back(mk("sll31",    4'd2, 0, 12'h000, 5'd3, 5'd7, 5'd17, 1'b1, 1'b1, 32'h8000_0000, 34, 11));
        vecs.push_back(mk("add_rd0",  4'd0, 0, 12'h000, 5'd1, 5'd3, 5'd0, 1'b0, 1'b1, 32'h0000_0000,  3,  3));
        vecs.push_back(mk("illegal",  4'd12, 0, 12'h000, 5'd1, 5'd3, 5'd18, 1'b0, 1'b0, 32'h0000_0000, 3,  3));

        in_rst = 1'b0; in_start = 1'b0; in_op = '0; in_use_imm = 1'b0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        repeat (3) @(negedge in_clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("reset/dut%0d/ctrl", i),
                        {12'd0, busy[i], done[i], wen[i], ren_1[i], ren_2[i], raddr_1[i], raddr_2[i], waddr[i]},
                        32'd0);
            checkOutput($sformatf("reset/dut%0d/wdata", i), wdata[i], 32'd0);
        end
        in_rst = 1'b1;

        $display("[TB] running %0d directed vectors", vecs.size());
        foreach (vecs[k]) applyStimulus(vecs[k], 0, 0);

        $display("[TB] start pulse while busy");
        applyStimulus(mk("busy_start", 4'd7, 0, 12'h000, 5'd6, 5'd7, 5'd3, 1'b1, 1'b1, 32'hFFFF_FFFF, 34, 11), 5, 0);

        $display("[TB] reset during shift, then fresh op");
        applyStimulus(mk("rst_shift", 4'd6, 0, 12'h000, 5'd6, 5'd7, 5'd20, 1'b0, 1'b0, 32'h0000_0000, 0, 0), 0, 10);
        applyStimulus(mk("xor_after", 4'd5, 0, 12'h000, 5'd8, 5'd9, 5'd21, 1'b1, 1'b1, 32'hFFFF_FFFF, 3, 3), 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
